// File: rtl/mem_pkg.sv
// mem_pkg: shared widths, types and mode encodings for the dual-read register file
package mem_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  localparam logic MODE_WRITE = 1'b0;
  localparam logic MODE_READ = 1'b1;
endpackage

// File: rtl/mem_read_port.sv
// mem_read_port: combinational word select with optional write-through forwarding (MEMORY_WRITE_BYPASS_EN)
module mem_read_port
  import mem_pkg::*;
(
  input  logic [DEPTH-1:0][DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [ADDR_W-1:0]            write_add,
  input  logic [DATA_W-1:0]            write_inp,
  input  logic                         bypass_en,
  output logic [DATA_W-1:0]            rd
);
`ifdef MEMORY_WRITE_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif
  always_comb begin
    rd = (BYPASS && bypass_en && addr == write_add) ? write_inp : mem[addr];
  end
endmodule

// File: rtl/dual_read_memory.sv
// dual_read_memory: 32x8 register file, one sync write port, two async read ports (MEMORY_WRITE_BYPASS_EN adds forwarding)
module dual_read_memory
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_add_1,
  input  logic [ADDR_W-1:0] read_add_2,
  input  logic [ADDR_W-1:0] write_add,
  input  logic [DATA_W-1:0] write_inp,
  input  logic              mode,
  output logic [DATA_W-1:0] read_out_1,
  output logic [DATA_W-1:0] read_out_2
);
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic bypass_en;
  assign bypass_en = (mode == MODE_WRITE) && !rst;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem <= '0;
    else if (mode == MODE_WRITE) mem[write_add] <= write_inp;
  end
  mem_read_port u_port_1 (
    .mem(mem), .addr(read_add_1), .write_add(write_add),
    .write_inp(write_inp), .bypass_en(bypass_en), .rd(read_out_1)
  );
  mem_read_port u_port_2 (
    .mem(mem), .addr(read_add_2), .write_add(write_add),
    .write_inp(write_inp), .bypass_en(bypass_en), .rd(read_out_2)
  );
endmodule

// File: tb/tb_dual_read_memory.sv
// tb_dual_read_memory: directed self-checking bench for dual_read_memory
module tb_dual_read_memory;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] read_add_1 = '0;
  logic [4:0] read_add_2 = '0;
  logic [4:0] write_add = '0;
  logic [7:0] write_inp = '0;
  logic mode = 1'b1;
  logic [7:0] read_out_1;
  logic [7:0] read_out_2;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  dual_read_memory dut (
    .clk(clk), .rst(rst), .read_add_1(read_add_1), .read_add_2(read_add_2),
    .write_add(write_add), .write_inp(write_inp), .mode(mode),
    .read_out_1(read_out_1), .read_out_2(read_out_2)
  );
  task automatic do_write(input logic [4:0] a, input logic [7:0] d);
    mode = 1'b0;
    write_add = a;
    write_inp = d;
    @(posedge clk);
    #1;
    mode = 1'b1;
  endtask
  task automatic test_reset;
    do_write(5'd11, 8'hA5);
    read_add_1 = 5'd11;
    read_add_2 = 5'd11;
    #1;
    checks++;
    if (read_out_1 !== 8'hA5) begin failures++; $display("FAIL reset_pre_write got=%h exp=%h", read_out_1, 8'hA5); end
    rst = 1'b1;
    #1;
    checks++;
    if (read_out_1 !== 8'h00) begin failures++; $display("FAIL reset_async_1 got=%h exp=00", read_out_1); end
    checks++;
    if (read_out_2 !== 8'h00) begin failures++; $display("FAIL reset_async_2 got=%h exp=00", read_out_2); end
    read_add_1 = 5'd0;
    read_add_2 = 5'd0;
    #1;
    checks++;
    if (read_out_1 !== 8'h00 || read_out_2 !== 8'h00) begin failures++; $display("FAIL reset_addr0 got=%h/%h exp=00/00", read_out_1, read_out_2); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    read_add_1 = 5'd11;
    read_add_2 = 5'd11;
    #1;
    checks++;
    if (read_out_1 !== 8'h00 || read_out_2 !== 8'h00) begin failures++; $display("FAIL reset_release got=%h/%h exp=00/00", read_out_1, read_out_2); end
  endtask
  task automatic test_basic;
    do_write(5'd11, 8'h3C);
    read_add_1 = 5'd11;
    read_add_2 = 5'd11;
    #1;
    checks++;
    if (read_out_1 !== 8'h3C) begin failures++; $display("FAIL basic_port1 got=%h exp=3c", read_out_1); end
    checks++;
    if (read_out_2 !== 8'h3C) begin failures++; $display("FAIL basic_port2 got=%h exp=3c", read_out_2); end
  endtask
  task automatic test_write_blocked;
    mode = 1'b1;
    write_add = 5'd11;
    write_inp = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (read_out_1 !== 8'h3C) begin failures++; $display("FAIL write_blocked got=%h exp=3c", read_out_1); end
    write_add = 'x;
    @(posedge clk);
    #1;
    checks++;
    if (read_out_2 !== 8'h3C) begin failures++; $display("FAIL write_blocked_x got=%h exp=3c", read_out_2); end
  endtask
  task automatic test_continuous;
    logic [7:0] v;
    mode = 1'b0;
    write_add = 5'd11;
    read_add_2 = 5'd11;
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom);
      write_inp = v;
      @(posedge clk);
      #1;
      checks++;
      if (read_out_2 !== v) begin failures++; $display("FAIL continuous[%0d] got=%h exp=%h", i, read_out_2, v); end
    end
    mode = 1'b1;
  endtask
  task automatic test_boundaries;
    do_write(5'd0, 8'h01);
    do_write(5'd31, 8'hFE);
    read_add_1 = 5'd0;
    read_add_2 = 5'd31;
    #1;
    checks++;
    if (read_out_1 !== 8'h01 || read_out_2 !== 8'hFE) begin failures++; $display("FAIL bound got=%h/%h exp=01/fe", read_out_1, read_out_2); end
    read_add_1 = 5'd31;
    read_add_2 = 5'd0;
    #1;
    checks++;
    if (read_out_1 !== 8'hFE || read_out_2 !== 8'h01) begin failures++; $display("FAIL bound_swap got=%h/%h exp=fe/01", read_out_1, read_out_2); end
  endtask
  task automatic test_bypass;
    logic [7:0] exp_pre;
`ifdef MEMORY_WRITE_BYPASS_EN
    exp_pre = 8'h77;
`else
    exp_pre = 8'h10;
`endif
    do_write(5'd5, 8'h10);
    read_add_1 = 5'd5;
    read_add_2 = 5'd0;
    mode = 1'b0;
    write_add = 5'd5;
    write_inp = 8'h77;
    #1;
    checks++;
    if (read_out_1 !== exp_pre) begin failures++; $display("FAIL bypass_pre got=%h exp=%h", read_out_1, exp_pre); end
    checks++;
    if (read_out_2 !== 8'h01) begin failures++; $display("FAIL bypass_other got=%h exp=01", read_out_2); end
    @(posedge clk);
    #1;
    mode = 1'b1;
    #1;
    checks++;
    if (read_out_1 !== 8'h77) begin failures++; $display("FAIL bypass_post got=%h exp=77", read_out_1); end
  endtask
  task automatic test_reset_wins;
    do_write(5'd3, 8'h99);
    rst = 1'b1;
    mode = 1'b0;
    write_add = 5'd3;
    write_inp = 8'h55;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode = 1'b1;
    read_add_1 = 5'd3;
    #1;
    checks++;
    if (read_out_1 !== 8'h00) begin failures++; $display("FAIL reset_wins got=%h exp=00", read_out_1); end
  endtask
  initial begin
    #1;
    checks++;
    if (read_out_1 !== 8'h00 || read_out_2 !== 8'h00) begin failures++; $display("FAIL initial_reset got=%h/%h exp=00/00", read_out_1, read_out_2); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset;
    test_basic;
    test_write_blocked;
    test_continuous;
    test_boundaries;
    test_bypass;
    test_reset_wins;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dual_read_memory.md
Name: dual_read_memory

Overview:
- 32-entry × 8-bit register-file memory with two independent read ports and one write port.
- Part of the register-file subsystem and serves as a general-purpose operand store.
- Writes are synchronous, gated by a single mode input.
- Reads are combinational.

Parameters:
- ADDR_W, 5, address width; depth = 2**ADDR_W entries.
- DATA_W, 8, width of each entry and of all data ports.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- read_add_1  input  ADDR_W  address for read port 1.
- read_add_2  input  ADDR_W  address for read port 2.
- write_add  input  ADDR_W  write address.
- write_inp  input  DATA_W  write data.
- mode  input  1  0 = write cycle, 1 = read-only cycle (no write).
- read_out_1  output  DATA_W  data at read_add_1.
- read_out_2  output  DATA_W  data at read_add_2.

Behaviour:
- Storage: 2**ADDR_W words of DATA_W bits.
- Reset: while rst=1, every entry is asynchronously cleared to 0. read_out_1 and read_out_2 therefore read 0 for any address. Deasserting rst has no other effect.
- Write: on rising clk with rst=0 and mode=0, mem[write_add] <= write_inp. With mode=1, no entry changes. mode, write_add and write_inp are sampled only at the clock edge.
- Read: read_out_1 = mem[read_add_1] and read_out_2 = mem[read_add_2], purely combinational with zero latency.
- Read-after-write: a value written at edge N appears on the outputs immediately after edge N.
- Both read ports may address the same entry, and either may equal write_add. The two ports are fully independent.
- Read-during-write (same address, same cycle, mode=0), macro absent: outputs show the old contents until the edge, then the new value.
- All addresses 0..31 are valid. There is no wrap or out-of-range case, and no hardwired-zero entry.
- Reset asserted in the same cycle as a write: reset wins, and the entry stays 0.
- X on write_add while mode=1 has no effect.

Optional Feature:
- Macro: MEMORY_WRITE_BYPASS_EN.
- Defined: while mode=0 and rst=0, any read port whose address equals write_add drives write_inp combinationally (write-through forwarding) instead of the stored word. Ports at other addresses are unaffected. Stored contents update at the edge as normal.
- Undefined: no forwarding; reads always return stored contents.

Decomposition:
- Shared package mem_pkg holds:
  - localparams ADDR_W=5 and DATA_W=8;
  - typedefs addr_t and data_t;
  - constants MODE_WRITE=1'b0 and MODE_READ=1'b1.
- One natural sub-module, mem_read_port: a combinational mux that selects a word from the array for a given address. It includes the optional bypass compare/select and is instantiated twice.
- The write logic and storage array stay in the top module.

Test Plan:
- Reset: assert rst mid-simulation after writing 8'hA5 to address 11. Expect read_out_1 = read_out_2 = 8'h00 for addresses 11 and 0 while rst=1 and after release.
- Basic write/read: mode=0, write_add=5'd11, write_inp=8'h3C, one edge. Then mode=1; both read addresses at 11 give 8'h3C on both outputs.
- Write blocked: mode=1, write_add=11, write_inp=8'hFF over 3 edges. Address 11 still reads the previously written 8'h3C.
- Continuous writes: mode=0, write_add=11, write_inp changes every cycle (random values). After each edge, read_out_2 equals the write_inp sampled at that edge.
- Independent ports and boundaries:
  - write 8'h01 to address 0 and 8'hFE to address 31;
  - read_add_1=0, read_add_2=31 gives 8'h01 and 8'hFE;
  - swapping the addresses swaps the outputs.
- Bypass (MEMORY_WRITE_BYPASS_EN defined vs undefined): address 5 holds 8'h10. Drive mode=0, write_add=5, write_inp=8'h77, read_add_1=5 before the edge. read_out_1 = 8'h77 with the macro, 8'h10 without. Both builds read 8'h77 after the edge.
